// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit with the architectural HI/LO registers: iterative shift-add multiply and restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are all zero.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iValid,
  input  logic [5:0]      iFun,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic            iFlush,
  output logic            oStall,
  output logic [XLEN-1:0] oHi,
  output logic [XLEN-1:0] oLo,
  output logic            oBusy,
  output logic            oDivZero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] FUN_MTHI = 6'h11;
  localparam logic [5:0] FUN_MTLO = 6'h13;
  localparam int CW = $clog2(XLEN);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                isDiv, negRes, negRem;
  logic [2*XLEN-1:0]   accR;   // multiply: partial product; divide: {remainder, dividend/quotient}
  logic [2*XLEN-1:0]   opA;    // multiply: shifted multiplicand
  logic [XLEN-1:0]     opB;    // multiply: shifted multiplier; divide: divisor

  // MULT/MULTU/DIV/DIVU occupy 0x18..0x1B; bit 1 selects divide, bit 0 clear means signed.
  logic isMulDiv, opSigned, start, lastIter;
  logic [XLEN-1:0] magA, magB;

  assign isMulDiv = iValid && (iFun[5:2] == 4'b0110);
  assign opSigned = ~iFun[0];
  assign start    = (state == IDLE) && isMulDiv && !iFlush;
  assign magA     = (opSigned && iA[XLEN-1]) ? -iA : iA;
  assign magB     = (opSigned && iB[XLEN-1]) ? -iB : iB;

  // Reset gates the stall so the pipeline is released the moment rst rises.
  assign oStall = !rst && (start || (state == BUSY && !iFlush));

  logic [2*XLEN-1:0] stepAcc, stepA;
  logic [XLEN-1:0]   stepB, diff, resHi, resLo, quo, rem;
  logic [XLEN:0]     remShift;
  logic [2*XLEN-1:0] prod;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    stepAcc  = accR;
    stepA    = opA;
    stepB    = opB;
    remShift = {accR[2*XLEN-1:XLEN], accR[XLEN-1]};
    diff     = remShift[XLEN-1:0] - opB;
    if (isDiv) begin
      if (remShift >= {1'b0, opB}) stepAcc = {diff, accR[XLEN-2:0], 1'b1};
      else                         stepAcc = {remShift[XLEN-1:0], accR[XLEN-2:0], 1'b0};
    end else begin
      if (opB[0]) stepAcc = accR + opA;
      stepA = opA << 1;
      stepB = opB >> 1;
    end
  end

  always_comb begin
    prod = negRes ? -stepAcc : stepAcc;
    quo  = negRes ? -stepAcc[XLEN-1:0] : stepAcc[XLEN-1:0];
    rem  = negRem ? -stepAcc[2*XLEN-1:XLEN] : stepAcc[2*XLEN-1:XLEN];
    if (isDiv) begin
      resHi = rem;
      resLo = quo;
    end else begin
      resHi = prod[2*XLEN-1:XLEN];
      resLo = prod[XLEN-1:0];
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign lastIter = (&cnt) || (!isDiv && stepB == '0);
`else
  assign lastIter = &cnt;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      isDiv    <= 1'b0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      accR     <= '0;
      opA      <= '0;
      opB      <= '0;
      oHi      <= '0;
      oLo      <= '0;
      oBusy    <= 1'b0;
      oDivZero <= 1'b0;
    end else begin
      oDivZero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            isDiv  <= iFun[1];
            negRes <= opSigned && (iA[XLEN-1] ^ iB[XLEN-1]);
            negRem <= opSigned && iA[XLEN-1];
            cnt    <= '0;
            opB    <= magB;
            if (iFun[1]) begin
              accR <= {{XLEN{1'b0}}, magA};
              opA  <= '0;
            end else begin
              accR <= '0;
              opA  <= {{XLEN{1'b0}}, magA};
            end
            if (iFun[1] && iB == '0) begin
              state    <= DONE;
              oDivZero <= 1'b1;
            end else begin
              state <= BUSY;
              oBusy <= 1'b1;
            end
          end else if (iValid && !iFlush && iFun == FUN_MTHI) begin
            oHi <= iA;
          end else if (iValid && !iFlush && iFun == FUN_MTLO) begin
            oLo <= iA;
          end
        end
        BUSY: begin
          if (iFlush) begin
            state <= IDLE;
            oBusy <= 1'b0;
          end else begin
            accR <= stepAcc;
            opA  <= stepA;
            opB  <= stepB;
            cnt  <= cnt + 1'b1;
            if (lastIter) begin
              state <= DONE;
              oBusy <= 1'b0;
              oHi   <= resHi;
              oLo   <= resLo;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a reference model pushes expected HI/LO, stall count and divide-by-zero
// flag to a scoreboard when an op is driven; entries are popped and compared when the op reaches DONE.
module tb_ex_muldiv;

  logic        clk = 1'b0, rst = 1'b0, iValid = 1'b0, iFlush = 1'b0;
  logic [5:0]  iFun = '0;
  logic [31:0] iA = '0, iB = '0;
  logic        oStall, oBusy, oDivZero;
  logic [31:0] oHi, oLo;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .iValid(iValid), .iFun(iFun), .iA(iA), .iB(iB),
    .iFlush(iFlush), .oStall(oStall), .oHi(oHi), .oLo(oLo), .oBusy(oBusy), .oDivZero(oDivZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mHi = '0, mLo = '0;
  int          checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mulStalls(input logic [5:0] fun, input logic [31:0] b);
    logic [31:0] m;
    int busy;
    m = (!fun[0] && b[31]) ? -b : b;
    busy = 1;
    for (int i = 0; i < 32; i++) if (m[i]) busy = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
    return 1 + busy;
`else
    return (busy > 0) ? 33 : 0;
`endif
  endfunction

  // Reference model: updates mHi/mLo and queues what the DUT must show in DONE.
  task automatic push(input logic [5:0] fun, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.dz = 1'b0;
    case (fun)
      6'h18: begin p = sa * sbv; {mHi, mLo} = p; e.stalls = mulStalls(fun, b); end
      6'h19: begin p = {32'b0, a} * {32'b0, b}; {mHi, mLo} = p; e.stalls = mulStalls(fun, b); end
      default: begin
        if (b == 0) begin
          e.dz = 1'b1;
          e.stalls = 1;
        end else begin
          e.stalls = 33;
          if (fun == 6'h1A) begin
            q = sa / sbv;
            r = sa % sbv;
          end else begin
            q = longint'({32'b0, a} / {32'b0, b});
            r = longint'({32'b0, a} % {32'b0, b});
          end
          mLo = q[31:0];
          mHi = r[31:0];
        end
      end
    endcase
    e.hi = mHi;
    e.lo = mLo;
    sb.push_back(e);
  endtask

  task automatic runOp(input string tag, input logic [5:0] fun, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n;
    n = 0;
    push(fun, a, b);
    @(negedge clk);
    iValid = 1'b1; iFun = fun; iA = a; iB = b;
    #1;
    while (oStall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    e = sb.pop_front();
    check({tag, " stalls"}, n, e.stalls);
    check({tag, " hi"}, oHi, e.hi);
    check({tag, " lo"}, oLo, e.lo);
    check({tag, " divzero"}, oDivZero, e.dz);
    check({tag, " busy in done"}, oBusy, 1'b0);
    @(negedge clk);
    iValid = 1'b0; iFun = '0;
    #1;
    check({tag, " divzero after done"}, oDivZero, 1'b0);
    check({tag, " idle stall"}, oStall, 1'b0);
  endtask

  task automatic mtOp(input logic [5:0] fun, input logic [31:0] v);
    @(negedge clk);
    iValid = 1'b1; iFun = fun; iA = v;
    #1;
    check("mt stall", oStall, 1'b0);
    @(negedge clk);
    iValid = 1'b0; iFun = '0;
    if (fun == 6'h11) mHi = v; else mLo = v;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset hi", oHi, 32'h0);
    check("reset lo", oLo, 32'h0);
    check("reset stall", oStall, 1'b0);
    check("reset busy", oBusy, 1'b0);
    check("reset divzero", oDivZero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    runOp("mult -1x2", 6'h18, 32'hFFFFFFFF, 32'h2);
    runOp("divu 100/7", 6'h1B, 32'd100, 32'd7);
    runOp("div -7/2", 6'h1A, 32'hFFFFFFF9, 32'd2);
    runOp("div min/-1", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
    runOp("multu max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    runOp("mult neg x neg", 6'h18, 32'hFFFF0000, 32'h80000001);
    runOp("div 9/-4", 6'h1A, 32'd9, 32'hFFFFFFFC);
    for (int i = 0; i < 6; i++) begin
      logic [5:0] f;
      f = 6'h18 + 6'($urandom_range(0, 3));
      runOp("random", f, $urandom, $urandom_range(1, 32'hFFFFFFFF));
    end

    mtOp(6'h11, 32'h1234);
    mtOp(6'h13, 32'h1234);
    #1;
    check("mthi value", oHi, 32'h1234);
    check("mtlo value", oLo, 32'h1234);
    runOp("div 5/0", 6'h1A, 32'd5, 32'd0);

    // Flush on the tenth BUSY cycle of MULTU 3x5.
    @(negedge clk);
    iValid = 1'b1; iFun = 6'h19; iA = 32'd3; iB = 32'd5;
    #1;
    check("flush start stall", oStall, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) iFlush = 1'b1;
      #1;
    end
    check("flush stall", oStall, 1'b0);
    check("flush busy before edge", oBusy, 1'b1);
    @(negedge clk);
    iFlush = 1'b0; iValid = 1'b0; iFun = '0;
    #1;
    check("flush idle", oBusy, 1'b0);
    check("flush hi kept", oHi, mHi);
    check("flush lo kept", oLo, mLo);
    runOp("multu 3x5", 6'h19, 32'd3, 32'd5);

    // Reset pulsed in the middle of a DIVU.
    @(negedge clk);
    iValid = 1'b1; iFun = 6'h1B; iA = 32'd1000; iB = 32'd3;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset hi", oHi, 32'h0);
    check("midreset lo", oLo, 32'h0);
    check("midreset stall", oStall, 1'b0);
    check("midreset busy", oBusy, 1'b0);
    check("midreset divzero", oDivZero, 1'b0);
    @(negedge clk);
    iValid = 1'b0; iFun = '0;
    rst = 1'b0;
    mHi = '0; mLo = '0;
    runOp("multu 7x1", 6'h19, 32'd7, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
